aib_cfg_avmm_rsp: RTL and testbench

AIB_CFG_AVMM_RSP -- requirements
Module: aib_cfg_avmm_rsp

---
 rtl/aib_cfg_avmm_rsp.sv | 78 +++++++
 tb/tb_aib_cfg_avmm_rsp.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aib_cfg_avmm_rsp.sv
// aib_cfg_avmm_rsp: per-channel AVMM config responder with wait states, six RW words, sticky status and ID word
module aib_cfg_avmm_rsp #(
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] ID_WORD     = 32'h0000_A1B0
) (
   input  logic         i_cfg_avmm_clk,
   input  logic         i_cfg_avmm_rst_n,
   input  logic [5:0]   i_channel_id,
   input  logic [16:0]  i_cfg_avmm_addr,
   input  logic [3:0]   i_cfg_avmm_byte_en,
   input  logic         i_cfg_avmm_read,
   input  logic         i_cfg_avmm_write,
   input  logic [31:0]  i_cfg_avmm_wdata,
   output logic [31:0]  o_cfg_avmm_rdata,
   output logic         o_cfg_avmm_rdatavld,
   output logic         o_cfg_avmm_waitreq,
   output logic [191:0] o_cfg_regs
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RDV} state_t;
   state_t state, nxt;
   logic [2:0] cnt, idx, sticky, clr, set;
   logic [7:0] wcnt;
   logic [5:0][31:0] regs;
   logic [31:0] status, rd_word, wmask;
   logic req, sel, mapped, wr_ack, rd_ack, unused_ok;

   assign o_cfg_regs = regs;
   assign unused_ok = ^i_cfg_avmm_addr[1:0];

   always_comb begin
      req = i_cfg_avmm_read | i_cfg_avmm_write;
      sel = req && i_cfg_avmm_addr[16:11] == i_channel_id;
      mapped = i_cfg_avmm_addr[10:5] == 6'd0;
      idx = i_cfg_avmm_addr[4:2];
      wr_ack = state == S_ACK && i_cfg_avmm_write;
      rd_ack = state == S_ACK && i_cfg_avmm_read && !i_cfg_avmm_write;
      status = {10'd0, i_channel_id, wcnt, 5'd0, sticky};
      rd_word = !mapped ? 32'd0 : idx == 3'd7 ? ID_WORD : idx == 3'd6 ? status : regs[idx];
      wmask = {{8{i_cfg_avmm_byte_en[3]}}, {8{i_cfg_avmm_byte_en[2]}},
               {8{i_cfg_avmm_byte_en[1]}}, {8{i_cfg_avmm_byte_en[0]}}};
      clr = wr_ack && mapped && idx == 3'd7 ? i_cfg_avmm_wdata[2:0] : 3'd0;
      set = {wr_ack && i_cfg_avmm_read, state == S_ACK && req && !mapped, state == S_WAIT && !req};
   end

   always_ff @(posedge i_cfg_avmm_clk)
      if (!i_cfg_avmm_rst_n) state <= S_IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = !sel ? S_IDLE : WAIT_STATES > 0 ? S_WAIT : S_ACK;
         S_WAIT:  nxt = !req ? S_IDLE : cnt <= 3'd1 ? S_ACK : S_WAIT;
         S_ACK:   nxt = rd_ack ? S_RDV : S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge i_cfg_avmm_clk)
      if (!i_cfg_avmm_rst_n) begin
         cnt <= 3'd0;
         o_cfg_avmm_waitreq <= 1'b1;
         o_cfg_avmm_rdatavld <= 1'b0;
         o_cfg_avmm_rdata <= 32'd0;
         regs <= '0;
         sticky <= 3'd0;
         wcnt <= 8'd0;
      end else begin
         o_cfg_avmm_waitreq <= nxt != S_ACK;
         o_cfg_avmm_rdatavld <= nxt == S_RDV;
         cnt <= state == S_IDLE && sel ? 3'(WAIT_STATES) : state == S_WAIT && cnt != 3'd0 ? cnt - 3'd1 : cnt;
         if (rd_ack) o_cfg_avmm_rdata <= rd_word;
         if (wr_ack) wcnt <= wcnt + 8'd1;
         if (wr_ack && mapped && idx < 3'd6) regs[idx] <= (regs[idx] & ~wmask) | (i_cfg_avmm_wdata & wmask);
         sticky <= (sticky & ~clr) | set;
      end
endmodule

// File: tb/tb_aib_cfg_avmm_rsp.sv
// tb_aib_cfg_avmm_rsp: randomized and directed checks of two responders (1 and 3 wait states) against a rule-level model
module tb_aib_cfg_avmm_rsp;
   localparam logic [31:0] ID = 32'h0000_A1B0;
   logic clk = 0, rst_n = 0;
   logic [5:0] ch = 6'd3;
   logic [16:0] addr = '0;
   logic [3:0] be = '0;
   logic [31:0] wd = '0;
   logic rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
   logic [31:0] rdata_a, rdata_b;
   logic vld_a, vld_b, wq_a, wq_b;
   logic [191:0] regs_a, regs_b;
   int tests = 0, fails = 0;
   logic [31:0] m_regs [6];
   logic [2:0] m_sticky;
   logic [7:0] m_wcnt;
   int ack_n;
   bit wq_after, vld, vld_after;
   logic [31:0] rdat, exp;

   always #5 clk = ~clk;

   aib_cfg_avmm_rsp #(.WAIT_STATES(1), .ID_WORD(ID)) dut_a (
      .i_cfg_avmm_clk(clk), .i_cfg_avmm_rst_n(rst_n), .i_channel_id(ch), .i_cfg_avmm_addr(addr),
      .i_cfg_avmm_byte_en(be), .i_cfg_avmm_read(rd_a), .i_cfg_avmm_write(wr_a), .i_cfg_avmm_wdata(wd),
      .o_cfg_avmm_rdata(rdata_a), .o_cfg_avmm_rdatavld(vld_a), .o_cfg_avmm_waitreq(wq_a), .o_cfg_regs(regs_a));
   aib_cfg_avmm_rsp #(.WAIT_STATES(3), .ID_WORD(ID)) dut_b (
      .i_cfg_avmm_clk(clk), .i_cfg_avmm_rst_n(rst_n), .i_channel_id(ch), .i_cfg_avmm_addr(addr),
      .i_cfg_avmm_byte_en(be), .i_cfg_avmm_read(rd_b), .i_cfg_avmm_write(wr_b), .i_cfg_avmm_wdata(wd),
      .o_cfg_avmm_rdata(rdata_b), .o_cfg_avmm_rdatavld(vld_b), .o_cfg_avmm_waitreq(wq_b), .o_cfg_regs(regs_b));

   function automatic logic [16:0] mk(input logic [5:0] c, input logic [5:0] u, input logic [2:0] w);
      return {c, u, w, 2'b00};
   endfunction

   function automatic logic [31:0] m_status();
      return {10'd0, ch, m_wcnt, 5'd0, m_sticky};
   endfunction

   function automatic logic [191:0] m_concat();
      logic [191:0] r;
      for (int i = 0; i < 6; i++) r[32*i +: 32] = m_regs[i];
      return r;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 6; i++) m_regs[i] = 32'd0;
      m_sticky = 3'd0;
      m_wcnt = 8'd0;
   endtask

   // applies the register-map rules for one command seen by the 1-wait-state responder
   task automatic m_apply(input bit r, input bit w, input logic [16:0] a, input logic [3:0] e,
                          input logic [31:0] d, output logic [31:0] x);
      bit mapped;
      int k;
      x = 32'd0;
      if (a[16:11] != ch) return;
      mapped = a[10:5] == 6'd0;
      k = int'(a[4:2]);
      if (r && !w) x = !mapped ? 32'd0 : k < 6 ? m_regs[k] : k == 6 ? m_status() : ID;
      if (w) begin
         m_wcnt = m_wcnt + 8'd1;
         if (mapped && k < 6)
            for (int b = 0; b < 4; b++) if (e[b]) m_regs[k][8*b +: 8] = d[8*b +: 8];
         if (mapped && k == 7) m_sticky = m_sticky & ~d[2:0];
      end
      if (r && w) m_sticky[2] = 1'b1;
      if (!mapped) m_sticky[1] = 1'b1;
   endtask

   task automatic txn(input bit b, input bit r, input bit w, input logic [16:0] a, input logic [3:0] e,
                      input logic [31:0] d, output int an, output bit wqa, output bit v,
                      output logic [31:0] rd_o, output bit va);
      @(negedge clk);
      addr = a; be = e; wd = d;
      if (b) begin rd_b = r; wr_b = w; end else begin rd_a = r; wr_a = w; end
      an = -1;
      for (int n = 1; n <= 20 && an < 0; n++) begin
         @(posedge clk); #1;
         if (!(b ? wq_b : wq_a)) an = n;
      end
      @(posedge clk); #1;
      rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
      wqa = b ? wq_b : wq_a;
      v = b ? vld_b : vld_a;
      rd_o = b ? rdata_b : rdata_a;
      @(posedge clk); #1;
      va = b ? vld_b : vld_a;
   endtask

   task automatic do_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      m_reset();
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (wq_a !== 1'b1 || wq_b !== 1'b1) begin fails++; $display("FAIL reset_waitreq got %b/%b exp 1/1", wq_a, wq_b); end
      tests++; if (vld_a !== 1'b0 || vld_b !== 1'b0) begin fails++; $display("FAIL reset_rdatavld got %b/%b exp 0/0", vld_a, vld_b); end
      tests++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h/%h exp 0", rdata_a, rdata_b); end
      tests++; if (regs_a !== 192'd0 || regs_b !== 192'd0) begin fails++; $display("FAIL reset_regs got %h/%h exp 0", regs_a, regs_b); end
      rst_n = 1;
      m_reset();
      m_apply(1, 0, mk(3, 0, 6), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== 32'h0003_0000) begin fails++; $display("FAIL reset_status got %h exp %h", rdat, 32'h0003_0000); end
   endtask

   task automatic test_write_read();
      m_apply(0, 1, mk(3, 0, 2), 4'hF, 32'h1234_5678, exp);
      txn(0, 0, 1, mk(3, 0, 2), 4'hF, 32'h1234_5678, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (ack_n != 2) begin fails++; $display("FAIL wr_ack_cycle got %0d exp 2", ack_n); end
      tests++; if (wq_after !== 1'b1 || vld !== 1'b0) begin fails++; $display("FAIL wr_after_ack got wq=%b vld=%b exp wq=1 vld=0", wq_after, vld); end
      m_apply(1, 0, mk(3, 0, 2), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 2), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (ack_n != 2) begin fails++; $display("FAIL rd_ack_cycle got %0d exp 2", ack_n); end
      tests++; if (vld !== 1'b1 || vld_after !== 1'b0) begin fails++; $display("FAIL rd_vld_pulse got %b,%b exp 1,0", vld, vld_after); end
      tests++; if (rdat !== 32'h1234_5678) begin fails++; $display("FAIL rd_data got %h exp %h", rdat, 32'h1234_5678); end
      tests++; if (regs_a[95:64] !== 32'h1234_5678) begin fails++; $display("FAIL regs_word2 got %h exp %h", regs_a[95:64], 32'h1234_5678); end
   endtask

   task automatic test_byte_en();
      m_apply(0, 1, mk(3, 0, 0), 4'b0101, 32'hAABB_CCDD, exp);
      txn(0, 0, 1, mk(3, 0, 0), 4'b0101, 32'hAABB_CCDD, ack_n, wq_after, vld, rdat, vld_after);
      m_apply(1, 0, mk(3, 0, 0), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 0), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== 32'h00BB_00DD) begin fails++; $display("FAIL byte_en_read got %h exp %h", rdat, 32'h00BB_00DD); end
      tests++; if (regs_a[31:0] !== 32'h00BB_00DD) begin fails++; $display("FAIL byte_en_regs got %h exp %h", regs_a[31:0], 32'h00BB_00DD); end
   endtask

   task automatic test_unselected();
      @(negedge clk);
      addr = mk(5, 0, 1); be = 4'hF; wd = 32'hDEAD_BEEF; rd_a = 1; wr_a = 1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         tests++;
         if (wq_a !== 1'b1 || vld_a !== 1'b0 || regs_a !== m_concat())
            begin fails++; $display("FAIL unselected_c%0d got wq=%b vld=%b regs=%h exp wq=1 vld=0 regs=%h", n, wq_a, vld_a, regs_a, m_concat()); end
      end
      rd_a = 0; wr_a = 0;
      m_apply(1, 0, mk(3, 0, 6), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== exp) begin fails++; $display("FAIL unselected_status got %h exp %h", rdat, exp); end
   endtask

   task automatic test_unmapped();
      m_apply(1, 0, mk(3, 1, 0), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 1, 0), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (ack_n != 2 || vld !== 1'b1 || rdat !== 32'd0)
         begin fails++; $display("FAIL unmapped_read got ack=%0d vld=%b data=%h exp ack=2 vld=1 data=0", ack_n, vld, rdat); end
      m_apply(1, 0, mk(3, 0, 6), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== exp || rdat[1] !== 1'b1) begin fails++; $display("FAIL unmapped_sticky got %h exp %h", rdat, exp); end
      m_apply(0, 1, mk(3, 0, 7), 4'h0, 32'h2, exp);
      txn(0, 0, 1, mk(3, 0, 7), 4'h0, 32'h2, ack_n, wq_after, vld, rdat, vld_after);
      m_apply(1, 0, mk(3, 0, 6), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== exp || rdat[1] !== 1'b0) begin fails++; $display("FAIL w1c_clear got %h exp %h", rdat, exp); end
      m_apply(1, 0, mk(3, 0, 7), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 7), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== ID) begin fails++; $display("FAIL id_word got %h exp %h", rdat, ID); end
   endtask

   task automatic test_conflict();
      m_apply(1, 1, mk(3, 0, 1), 4'hF, 32'h5A5A_0F0F, exp);
      txn(0, 1, 1, mk(3, 0, 1), 4'hF, 32'h5A5A_0F0F, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (ack_n != 2 || vld !== 1'b0 || vld_after !== 1'b0)
         begin fails++; $display("FAIL conflict_hs got ack=%0d vld=%b,%b exp ack=2 vld=0,0", ack_n, vld, vld_after); end
      tests++; if (regs_a[63:32] !== 32'h5A5A_0F0F) begin fails++; $display("FAIL conflict_commit got %h exp %h", regs_a[63:32], 32'h5A5A_0F0F); end
      m_apply(1, 0, mk(3, 0, 6), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== exp || rdat[2] !== 1'b1) begin fails++; $display("FAIL conflict_sticky got %h exp %h", rdat, exp); end
      // conflicting W1C to the status word: the conflict set must beat the clear
      m_apply(1, 1, mk(3, 0, 7), 4'hF, 32'h7, exp);
      txn(0, 1, 1, mk(3, 0, 7), 4'hF, 32'h7, ack_n, wq_after, vld, rdat, vld_after);
      m_apply(1, 0, mk(3, 0, 6), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== exp || rdat[2:0] !== 3'b100) begin fails++; $display("FAIL set_wins got %h exp %h", rdat, exp); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         logic [5:0] c, u;
         logic [2:0] w;
         logic [3:0] e;
         logic [31:0] d;
         bit r, wr;
         int op;
         c = $urandom_range(0, 4) == 0 ? 6'd5 : 6'd3;
         u = $urandom_range(0, 5) == 0 ? 6'($urandom_range(1, 63)) : 6'd0;
         w = 3'($urandom_range(0, 7));
         e = 4'($urandom);
         d = $urandom;
         op = $urandom_range(1, 3);
         r = op[0]; wr = op[1];
         m_apply(r, wr, mk(c, u, w), e, d, exp);
         if (c != ch) begin
            @(negedge clk);
            addr = mk(c, u, w); be = e; wd = d; rd_a = r; wr_a = wr;
            repeat (3) begin
               @(posedge clk); #1;
               tests++; if (wq_a !== 1'b1 || vld_a !== 1'b0) begin fails++; $display("FAIL rand_unsel_%0d got wq=%b vld=%b exp 1,0", i, wq_a, vld_a); end
            end
            rd_a = 0; wr_a = 0;
         end else begin
            txn(0, r, wr, mk(c, u, w), e, d, ack_n, wq_after, vld, rdat, vld_after);
            tests++;
            if (ack_n != 2 || wq_after !== 1'b1 || vld !== (r && !wr) || vld_after !== 1'b0 || (r && !wr && rdat !== exp))
               begin fails++; $display("FAIL rand_txn_%0d got ack=%0d wq=%b vld=%b,%b data=%h exp ack=2 wq=1 vld=%b,0 data=%h",
                                       i, ack_n, wq_after, vld, vld_after, rdat, r && !wr, exp); end
         end
      end
      tests++; if (regs_a !== m_concat()) begin fails++; $display("FAIL rand_regs got %h exp %h", regs_a, m_concat()); end
      m_apply(1, 0, mk(3, 0, 6), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== exp) begin fails++; $display("FAIL rand_status got %h exp %h", rdat, exp); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 255; i++) begin
         d_loop: begin
            logic [31:0] d;
            d = $urandom;
            m_apply(0, 1, mk(3, 0, 3), 4'hF, d, exp);
            txn(0, 0, 1, mk(3, 0, 3), 4'hF, d, ack_n, wq_after, vld, rdat, vld_after);
         end
      end
      m_apply(1, 0, mk(3, 0, 6), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== exp || rdat[15:8] !== 8'd255) begin fails++; $display("FAIL count_255 got %h exp %h", rdat, exp); end
      m_apply(0, 1, mk(3, 0, 3), 4'hF, 32'h1, exp);
      txn(0, 0, 1, mk(3, 0, 3), 4'hF, 32'h1, ack_n, wq_after, vld, rdat, vld_after);
      m_apply(1, 0, mk(3, 0, 6), 4'hF, 0, exp);
      txn(0, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (rdat !== exp || rdat[15:8] !== 8'd0) begin fails++; $display("FAIL count_wrap got %h exp %h", rdat, exp); end
   endtask

   task automatic test_wait3();
      bit seen;
      int n;
      txn(1, 0, 1, mk(3, 0, 4), 4'hF, 32'hCAFE_F00D, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (ack_n != 4) begin fails++; $display("FAIL ws3_ack_cycle got %0d exp 4", ack_n); end
      @(negedge clk);
      addr = mk(3, 0, 4); rd_b = 1;
      repeat (2) @(posedge clk);
      #1 rd_b = 0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin @(posedge clk); #1; if (wq_b !== 1'b1 || vld_b !== 1'b0) seen = 1; end
      tests++; if (seen) begin fails++; $display("FAIL ws3_abort_handshake got activity exp none"); end
      txn(1, 1, 0, mk(3, 0, 6), 4'hF, 0, ack_n, wq_after, vld, rdat, vld_after);
      tests++; if (ack_n != 4 || rdat !== {10'd0, 6'd3, 8'd1, 5'd0, 3'b001})
         begin fails++; $display("FAIL ws3_abort_status got ack=%0d data=%h exp ack=4 data=%h", ack_n, rdat, {10'd0, 6'd3, 8'd1, 5'd0, 3'b001}); end
      @(negedge clk);
      addr = mk(3, 0, 4); rd_b = 1;
      n = 0;
      while (wq_b !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
      tests++; if (n != 4) begin fails++; $display("FAIL ws3_rdv_ack got %0d exp 4", n); end
      rst_n = 0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (vld_b !== 1'b0) seen = 1; end
      rd_b = 0; rst_n = 1;
      for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (vld_b !== 1'b0) seen = 1; end
      m_reset();
      tests++; if (seen) begin fails++; $display("FAIL rst_rdv_vld got pulse exp none"); end
      tests++; if (regs_b !== 192'd0 || regs_a !== 192'd0 || rdata_b !== 32'd0)
         begin fails++; $display("FAIL rst_rdv_regs got %h/%h rdata=%h exp 0", regs_b, regs_a, rdata_b); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_en();
      test_unselected();
      test_unmapped();
      test_conflict();
      test_random();
      test_wrap();
      test_wait3();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end
endmodule
